// File: rtl/assoc_array_pkg.sv
// Shared types and default sizes for the associative key/value table.
package assoc_array_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_KEY_W  = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_READ   = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/assoc_prio_enc.sv
// Lowest-set-bit priority encoder; used to find the first free table slot.
module assoc_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]         vec_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);
    localparam int IW = $clog2(N);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Scan downward so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/assoc_array_table.sv
// Small fully-associative key/value table: one request at a time through IDLE -> MATCH -> RESP.
module assoc_array_table
    import assoc_array_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [KEY_W-1:0]         req_key,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_hit,
    output logic                     resp_err,
    output logic [DATA_W-1:0]        resp_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [KEY_W-1:0]    key_q;
    logic [DATA_W-1:0]   data_q;
    logic [DEPTH-1:0]    valid_q;
    logic [KEY_W-1:0]    key_mem  [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [CW-1:0]       count_q;
    logic                resp_valid_q, resp_hit_q, resp_err_q;
    logic [DATA_W-1:0]   resp_data_q;

    logic [DEPTH-1:0]    hit_vec;
    logic                hit_any;
    logic [DATA_W-1:0]   hit_data;
    logic [IW-1:0]       free_idx;
    logic                free_any;

    assoc_prio_enc #(.N(DEPTH)) u_free_enc (
        .vec_i (~valid_q),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    always_comb begin
        hit_vec  = '0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid_q[i] && (key_mem[i] == key_q);
            if (hit_vec[i]) hit_data = hit_data | data_mem[i];
        end
        hit_any = |hit_vec;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_MATCH;
            end
            ST_MATCH: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q   <= op_e'(req_op);
                        key_q  <= req_key;
                        data_q <= req_data;
                    end
                end
                ST_MATCH: begin
                    // Table update and response are committed together on leaving MATCH.
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= (op_q != OP_CLEAR) && hit_any;
                    resp_err_q   <= 1'b0;
                    resp_data_q  <= '0;
                    case (op_q)
                        OP_WRITE: begin
                            if (hit_any) begin
                                for (int i = 0; i < DEPTH; i++) begin
                                    if (hit_vec[i]) data_mem[i] <= data_q;
                                end
                            end else if (free_any) begin
                                valid_q[free_idx]  <= 1'b1;
                                key_mem[free_idx]  <= key_q;
                                data_mem[free_idx] <= data_q;
                                count_q            <= count_q + CW'(1);
                            end else begin
                                resp_err_q <= 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (hit_any) resp_data_q <= hit_data;
                        end
                        OP_DELETE: begin
                            if (hit_any) begin
                                valid_q <= valid_q & ~hit_vec;
                                count_q <= count_q - CW'(1);
                            end
                        end
                        OP_CLEAR: begin
                            valid_q <= '0;
                            count_q <= '0;
                        end
                        default: ;
                    endcase
                end
                ST_RESP: begin
                    if (resp_ready) resp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign count      = count_q;

endmodule

// File: doc/assoc_array_table.md
ASSOC_ARRAY_TABLE -- requirements
Module: assoc_array_table

Interface
REQ-001 Parameter DEPTH, default 8, meaning number of key/value entries (power of two, 2..64).
REQ-002 Parameter KEY_W, default 32, meaning key width in bits.
REQ-003 Parameter DATA_W, default 32, meaning value width in bits.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_op  input  2  operation: WRITE=0, READ=1, DELETE=2, CLEAR=3.
REQ-009 req_key  input  KEY_W  lookup key; ignored for CLEAR.
REQ-010 req_data  input  DATA_W  value to store; used only for WRITE.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  consumer accepts the response.
REQ-013 resp_hit  output  1  key was present before the operation.
REQ-014 resp_err  output  1  WRITE to a new key while the table is full.
REQ-015 resp_data  output  DATA_W  READ: stored value on hit, zero on miss; zero for all other ops.
REQ-016 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 FSM states IDLE, MATCH, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE -> MATCH when req_valid && req_ready; op, key and data SHALL be captured that cycle.
REQ-019 MATCH SHALL register a one-hot hit vector (valid && key equal) and the lowest free index, then go to RESP.
REQ-020 Table update and response fields SHALL be committed on the MATCH -> RESP edge; resp_valid asserts 2 cycles after acceptance.
REQ-021 RESP -> IDLE when resp_ready is 1; resp_* SHALL hold stable while resp_valid && !resp_ready.
REQ-022 WRITE hit: overwrite value, count unchanged, resp_hit=1.
REQ-023 WRITE miss, not full: store at lowest free index, count+1, resp_hit=0.
REQ-024 WRITE miss, full (count==DEPTH): no table change, resp_err=1, resp_hit=0.
REQ-025 READ: no table change; resp_hit and resp_data per REQ-013/REQ-015.
REQ-026 DELETE hit: clear that entry's valid bit, count-1; DELETE miss: no change, resp_hit=0.
REQ-027 CLEAR: all valid bits cleared, count=0, resp_hit=0, resp_err=0.
REQ-028 Keys SHALL be unique in the table; at most one hit bit is ever set.
REQ-029 count SHALL never exceed DEPTH nor underflow below 0.
REQ-030 Back-to-back requests: minimum 3 cycles per operation with resp_ready held 1.

Reset
REQ-031 rst SHALL force state IDLE, all valid bits 0, count=0, resp_valid=0, resp_hit=0, resp_err=0, resp_data=0; req_ready=1 the cycle after rst deasserts.
REQ-032 rst during MATCH or RESP SHALL abandon the operation with no table update and no response.
REQ-033 Stored key/value storage SHALL NOT require reset.

Structure
REQ-034 Package assoc_array_pkg SHALL hold the op enum, FSM state enum and default parameter constants.
REQ-035 One sub-module assoc_prio_enc SHALL produce the lowest-set index and an any-set flag from the inverted valid vector.

Verification
REQ-036 WRITE 80->81, WRITE 0->1, READ 80 -> resp_hit=1, resp_data=81, count=2.
REQ-037 WRITE 80->99 after REQ-036 -> resp_hit=1, count stays 2; READ 80 -> 99.
REQ-038 Fill 8 distinct keys, WRITE key 100 -> resp_err=1, count=8; READ 100 -> resp_hit=0, resp_data=0.
REQ-039 DELETE 0 -> resp_hit=1, count-1; READ 0 -> resp_hit=0; DELETE 0 again -> resp_hit=0, count unchanged.
REQ-040 Hold resp_ready=0 for 3 cycles on a READ -> resp_* stable, req_ready=0 throughout; accepted on 4th cycle.
REQ-041 Assert rst in MATCH of a WRITE 5->6 -> after reset count=0, READ 5 -> resp_hit=0, no stray resp_valid.
